// File: rtl/yolov4_param_tx_pkg.sv
// yolov4_param_tx_pkg: section tags, FSM encodings and section sequencing for the parameter transmitter
// Tag and state values follow the receiver's RECEIVE_SCALE -> RECEIVE_WEIGHT -> RECEIVE_BIAS order,
// so SEND_x == tag + 1.
package yolov4_param_tx_pkg;

    localparam int TAG_W = 3;

    typedef enum logic [1:0] {
        SEC_SCALE  = 2'd0,
        SEC_WEIGHT = 2'd1,
        SEC_BIAS   = 2'd2
    } sec_t;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_SEND_SCALE  = 3'd1,
        S_SEND_WEIGHT = 3'd2,
        S_SEND_BIAS   = 3'd3,
        S_FINISH      = 3'd4
    } state_t;

    // First section at index >= from whose length is nonzero, else FINISH.
    function automatic state_t next_sec(input logic [2:0] nz, input logic [1:0] from);
        next_sec = S_FINISH;
        for (int i = 2; i >= 0; i--)
            if (i >= int'(from) && nz[i]) next_sec = state_t'(3'(i + 1));
    endfunction

endpackage

// File: rtl/yolov4_param_tx_if.sv
// yolov4_param_tx_if: configuration, status, memory-read and stream signals of the parameter transmitter
// master: transmitter side (drives status, memory reads and the stream)
// slave : environment side (drives config, start, read data and m_ready)
interface yolov4_param_tx_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] scale_base, weight_base, bias_base;
    logic [CNT_W-1:0]  scale_len, weight_len, bias_len;
    logic              busy, done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              m_valid, m_ready, m_last;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        m_type;

    modport master (
        input  start, scale_base, weight_base, bias_base, scale_len, weight_len, bias_len,
        input  mem_rd_data, m_ready,
        output busy, done, mem_rd_en, mem_addr, m_valid, m_data, m_type, m_last
    );

    modport slave (
        output start, scale_base, weight_base, bias_base, scale_len, weight_len, bias_len,
        output mem_rd_data, m_ready,
        input  busy, done, mem_rd_en, mem_addr, m_valid, m_data, m_type, m_last
    );
endinterface

// File: rtl/yolov4_skid_fifo.sv
// yolov4_skid_fifo: 2-entry FIFO whose head entry is a register driving the output directly
// Ports: clk, rst (async, active-high); push_i/din_i write; pop_i removes head;
//        dout_o head entry; full_o, empty_o, count_o occupancy.
module yolov4_skid_fifo #(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] head_q, spare_q;
    logic [1:0]   count_q;

    assign dout_o  = head_q;
    assign count_o = count_q;
    assign full_o  = count_q == 2'd2;
    assign empty_o = count_q == 2'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            spare_q <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
            if (pop_i && full_o) head_q <= spare_q;
            else if (push_i && (empty_o || (pop_i && count_q == 2'd1))) head_q <= din_i;
            if (push_i && ((count_q == 2'd1 && !pop_i) || (full_o && pop_i))) spare_q <= din_i;
        end
    end
endmodule

// File: rtl/yolov4_param_tx.sv
// yolov4_param_tx: streams scale, weight and bias sections from parameter BRAM as tagged beats
// Ports: clk, rst (async, active-high);
//        bus.master: start + per-section base/len in, busy/done out,
//        mem_rd_en/mem_addr out with mem_rd_data returning one cycle later,
//        m_valid/m_data/m_type/m_last out with m_ready in.
module yolov4_param_tx
    import yolov4_param_tx_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input logic               clk,
    input logic               rst,
    yolov4_param_tx_if.master bus
);
    state_t                   state_q, nxt_st;
    logic [ADDR_W-1:0]        base_q [3];
    logic [CNT_W-1:0]         len_q [3];
    logic [ADDR_W-1:0]        base_in [3];
    logic [CNT_W-1:0]         cnt_q;
    logic [ADDR_W-1:0]        addr_q, nxt_base;
    logic [TAG_W-1:0]         tag_q;
    logic                     inflight_q, busy_q, done_q;
    logic                     idle, send, pop, issue, is_last;
    logic                     fifo_full, fifo_empty;
    logic [1:0]               fifo_count, sec, nidx;
    logic [2:0]               occ, nz_in, nz_q;
    logic [DATA_W+TAG_W-1:0]  fifo_dout;

    assign idle    = state_q == S_IDLE;
    assign send    = state_q inside {S_SEND_SCALE, S_SEND_WEIGHT, S_SEND_BIAS};
    assign sec     = send ? state_q[1:0] - 2'd1 : 2'd0;
    assign base_in = '{bus.scale_base, bus.weight_base, bus.bias_base};
    assign nz_in   = {bus.bias_len != '0, bus.weight_len != '0, bus.scale_len != '0};
    assign nz_q    = {len_q[2] != '0, len_q[1] != '0, len_q[0] != '0};
    assign nxt_st  = idle ? next_sec(nz_in, 2'd0) : next_sec(nz_q, sec + 2'd1);
    assign nidx    = nxt_st[1:0] - 2'd1;
    assign nxt_base = (nxt_st == S_FINISH) ? '0 : idle ? base_in[nidx] : base_q[nidx];

    // Credit counts the beat leaving this cycle, so a read can be issued while the
    // single buffered beat is being popped; this sustains one beat per cycle.
    assign pop     = !fifo_empty && bus.m_ready;
    assign occ     = {1'b0, fifo_count} + {2'b0, inflight_q};
    assign issue   = send && (occ < 3'd2 + {2'b0, pop});
    assign is_last = cnt_q == len_q[sec] - CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '{default: '0};
            len_q      <= '{default: '0};
            cnt_q      <= '0;
            addr_q     <= '0;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            if (issue) begin
                tag_q  <= {sec, is_last};
                cnt_q  <= cnt_q + CNT_W'(1);
                addr_q <= addr_q + ADDR_W'(1);
            end
            case (state_q)
                S_IDLE: if (bus.start) begin
                    base_q  <= base_in;
                    len_q   <= '{bus.scale_len, bus.weight_len, bus.bias_len};
                    // An all-empty transfer completes directly without visiting FINISH.
                    state_q <= (nxt_st == S_FINISH) ? S_IDLE : nxt_st;
                    busy_q  <= nxt_st != S_FINISH;
                    done_q  <= nxt_st == S_FINISH;
                    cnt_q   <= '0;
                    addr_q  <= nxt_base;
                end
                // Done fires once the last beat handshakes in this very cycle or already has.
                S_FINISH: if (!fifo_full && !inflight_q && (fifo_empty || pop)) begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: if (issue && is_last) begin
                    state_q <= nxt_st;
                    cnt_q   <= '0;
                    addr_q  <= nxt_base;
                end
            endcase
        end
    end

    yolov4_skid_fifo #(.W(DATA_W + TAG_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .din_i   ({tag_q, bus.mem_rd_data}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_rd_en = issue;
    assign bus.mem_addr  = addr_q;
    assign bus.m_valid   = !fifo_empty;
    assign bus.m_type    = fifo_dout[DATA_W+2:DATA_W+1];
    assign bus.m_last    = fifo_dout[DATA_W];
    assign bus.m_data    = fifo_dout[DATA_W-1:0];
endmodule

// File: tb/tb_yolov4_param_tx.sv
// tb_yolov4_param_tx: directed bench for the parameter transmitter with a BRAM model and stream monitor
module tb_yolov4_param_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    yolov4_param_tx_if #(.DATA_W(32), .ADDR_W(16), .CNT_W(16)) bus ();
    yolov4_param_tx dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input logic [15:0] a);
        return {16'hC0DE, a};
    endfunction

    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= memf(bus.mem_addr);

    logic [15:0] rd_addr [$];
    logic [31:0] b_data [$];
    logic [1:0]  b_type [$];
    logic        b_last [$];
    int          b_cyc [$];
    int          issued, done_cnt, done_cyc, first_rd, first_v, first_busy, stall_err, credit_err;
    logic        prev_v, prev_hs;
    logic [34:0] prev_beat;

    logic [15:0] ea [6] = '{16'h10, 16'h11, 16'h20, 16'h21, 16'h22, 16'h30};
    logic [1:0]  et [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    logic        el [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_rd_en && (issued - b_data.size() - int'(bus.m_valid & bus.m_ready)) >= 2) credit_err++;
            if (prev_v && !prev_hs && !(bus.m_valid && {bus.m_type, bus.m_last, bus.m_data} == prev_beat)) stall_err++;
            if (bus.m_valid && bus.m_ready) begin
                b_data.push_back(bus.m_data);
                b_type.push_back(bus.m_type);
                b_last.push_back(bus.m_last);
                b_cyc.push_back(cyc);
            end
            if (bus.mem_rd_en) begin
                rd_addr.push_back(bus.mem_addr);
                issued++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (bus.m_valid && first_v < 0) first_v = cyc;
            if (bus.busy && first_busy < 0) first_busy = cyc;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_v    = bus.m_valid;
            prev_hs   = bus.m_valid & bus.m_ready;
            prev_beat = {bus.m_type, bus.m_last, bus.m_data};
        end
    end

    function automatic logic rdy(input int mode, input int k);
        logic [8:0] bp;
        bp = 9'b0_0000_0101;
        if (mode != 1 || k < 0 || k > 8) return 1'b1;
        return bp[k];
    endfunction

    // mode 0: ready high; 1: backpressure pattern; 2: second start mid-weight; 3: reset mid-stream
    task automatic go(input logic [15:0] sb, sl, wb, wl, bb, bl, input int mode, output int t0);
        issued = 0; done_cnt = 0; done_cyc = -1; first_rd = -1; first_v = -1; first_busy = -1;
        stall_err = 0; credit_err = 0; prev_v = 1'b0; prev_hs = 1'b0;
        rd_addr.delete(); b_data.delete(); b_type.delete(); b_last.delete(); b_cyc.delete();
        @(posedge clk); #1;
        bus.scale_base = sb; bus.scale_len = sl;
        bus.weight_base = wb; bus.weight_len = wl;
        bus.bias_base = bb; bus.bias_len = bl;
        bus.start = 1'b1; bus.m_ready = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 300 && done_cnt == 0; k++) begin
            @(posedge clk); #1;
            bus.start = (mode == 2 && cyc == t0 + 4);
            if (bus.start) begin
                bus.scale_len = 16'd5;
                bus.bias_base = 16'h40;
            end
            bus.m_ready = rdy(mode, cyc - t0 - 3);
            if (mode == 3 && cyc == t0 + 5) begin
                rst = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
        bus.m_ready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if ({bus.busy, bus.done, bus.mem_rd_en, bus.m_valid, bus.m_last} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000", {bus.busy, bus.done, bus.mem_rd_en, bus.m_valid, bus.m_last});
        end
        total++; if (bus.mem_addr !== 16'h0) begin bad++; $display("FAIL reset_addr: got %h want 0000", bus.mem_addr); end
        total++; if (bus.m_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.m_data); end
        total++; if (bus.m_type !== 2'd0) begin bad++; $display("FAIL reset_type: got %0d want 0", bus.m_type); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int t0;
        go(16'h10, 16'd2, 16'h20, 16'd3, 16'h30, 16'd1, 0, t0);
        total++; if (first_rd !== t0 + 1) begin bad++; $display("FAIL basic_first_rd: got %0d want %0d", first_rd, t0 + 1); end
        total++; if (first_v !== t0 + 3) begin bad++; $display("FAIL basic_first_valid: got %0d want %0d", first_v, t0 + 3); end
        total++; if (first_busy !== t0 + 1) begin bad++; $display("FAIL basic_busy_rise: got %0d want %0d", first_busy, t0 + 1); end
        total++; if (b_data.size() != 6) begin bad++; $display("FAIL basic_count: got %0d want 6", b_data.size()); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (i >= b_data.size()) begin bad++; $display("FAIL basic_beat%0d: missing", i); end
            else if ({b_data[i], b_type[i], b_last[i]} !== {memf(ea[i]), et[i], el[i]}) begin
                bad++; $display("FAIL basic_beat%0d: got %h/%0d/%0d want %h/%0d/%0d", i, b_data[i], b_type[i], b_last[i], memf(ea[i]), et[i], el[i]);
            end
            total++;
            if (i >= rd_addr.size() || rd_addr[i] !== ea[i]) begin
                bad++; $display("FAIL basic_rdaddr%0d: got %h want %h", i, (i < rd_addr.size()) ? rd_addr[i] : 16'hxxxx, ea[i]);
            end
        end
        if (b_cyc.size() == 6) begin
            total++; if (b_cyc[5] - b_cyc[0] != 5) begin bad++; $display("FAIL basic_rate: got span %0d want 5", b_cyc[5] - b_cyc[0]); end
            total++; if (done_cyc != b_cyc[5] + 1) begin bad++; $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc, b_cyc[5] + 1); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", bus.busy); end
    endtask

    task automatic test_backpressure();
        int t0;
        go(16'h10, 16'd2, 16'h20, 16'd3, 16'h30, 16'd1, 1, t0);
        total++; if (b_data.size() != 6) begin bad++; $display("FAIL bp_count: got %0d want 6", b_data.size()); end
        for (int i = 0; i < 6 && i < b_data.size(); i++) begin
            total++;
            if ({b_data[i], b_type[i], b_last[i]} !== {memf(ea[i]), et[i], el[i]}) begin
                bad++; $display("FAIL bp_beat%0d: got %h/%0d/%0d want %h/%0d/%0d", i, b_data[i], b_type[i], b_last[i], memf(ea[i]), et[i], el[i]);
            end
        end
        total++; if (stall_err != 0) begin bad++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err); end
        total++; if (credit_err != 0) begin bad++; $display("FAIL bp_credit: got %0d over-credit reads want 0", credit_err); end
        if (b_cyc.size() == 6) begin
            total++; if (b_cyc[5] - b_cyc[0] <= 5) begin bad++; $display("FAIL bp_stalled: got span %0d want >5", b_cyc[5] - b_cyc[0]); end
            total++; if (done_cyc != b_cyc[5] + 1) begin bad++; $display("FAIL bp_done_cyc: got %0d want %0d", done_cyc, b_cyc[5] + 1); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_zero_weight();
        int t0;
        logic [15:0] za [3] = '{16'h10, 16'h11, 16'h30};
        logic [1:0]  zt [3] = '{2'd0, 2'd0, 2'd2};
        logic        zl [3] = '{1'b0, 1'b1, 1'b1};
        go(16'h10, 16'd2, 16'h20, 16'd0, 16'h30, 16'd1, 0, t0);
        total++; if (b_data.size() != 3) begin bad++; $display("FAIL zw_count: got %0d want 3", b_data.size()); end
        for (int i = 0; i < 3 && i < b_data.size(); i++) begin
            total++;
            if ({b_data[i], b_type[i], b_last[i]} !== {memf(za[i]), zt[i], zl[i]}) begin
                bad++; $display("FAIL zw_beat%0d: got %h/%0d/%0d want %h/%0d/%0d", i, b_data[i], b_type[i], b_last[i], memf(za[i]), zt[i], zl[i]);
            end
        end
        if (b_cyc.size() == 3) begin
            total++; if (b_cyc[2] != b_cyc[1] + 1) begin bad++; $display("FAIL zw_no_bubble: got gap %0d want 1", b_cyc[2] - b_cyc[1]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL zw_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_all_zero();
        int t0;
        go(16'h10, 16'd0, 16'h20, 16'd0, 16'h30, 16'd0, 0, t0);
        total++; if (done_cyc != t0 + 1) begin bad++; $display("FAIL az_done_cyc: got %0d want %0d", done_cyc, t0 + 1); end
        total++; if (issued != 0) begin bad++; $display("FAIL az_reads: got %0d want 0", issued); end
        total++; if (first_v != -1) begin bad++; $display("FAIL az_valid: got first valid at %0d want never", first_v); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL az_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_wrap();
        int t0;
        logic [15:0] wa [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        logic        wl [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        go(16'h0, 16'd0, 16'hFFFE, 16'd4, 16'h0, 16'd0, 0, t0);
        total++; if (b_data.size() != 4) begin bad++; $display("FAIL wrap_count: got %0d want 4", b_data.size()); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= rd_addr.size() || rd_addr[i] !== wa[i]) begin
                bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, (i < rd_addr.size()) ? rd_addr[i] : 16'hxxxx, wa[i]);
            end
            if (i < b_data.size()) begin
                total++;
                if ({b_data[i], b_type[i], b_last[i]} !== {memf(wa[i]), 2'd1, wl[i]}) begin
                    bad++; $display("FAIL wrap_beat%0d: got %h/%0d/%0d want %h/1/%0d", i, b_data[i], b_type[i], b_last[i], memf(wa[i]), wl[i]);
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        int t0;
        go(16'h10, 16'd2, 16'h20, 16'd3, 16'h30, 16'd1, 2, t0);
        total++; if (b_data.size() != 6) begin bad++; $display("FAIL busy_count: got %0d want 6", b_data.size()); end
        for (int i = 0; i < 6 && i < b_data.size(); i++) begin
            total++;
            if ({b_data[i], b_type[i], b_last[i]} !== {memf(ea[i]), et[i], el[i]}) begin
                bad++; $display("FAIL busy_beat%0d: got %h/%0d/%0d want %h/%0d/%0d", i, b_data[i], b_type[i], b_last[i], memf(ea[i]), et[i], el[i]);
            end
        end
        repeat (10) @(negedge clk);
        total++; if (issued != 6) begin bad++; $display("FAIL busy_reads_after: got %0d want 6", issued); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL busy_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_mid_reset();
        int t0;
        go(16'h10, 16'd2, 16'h20, 16'd3, 16'h30, 16'd1, 3, t0);
        #1;
        total++; if ({bus.busy, bus.done, bus.mem_rd_en, bus.m_valid, bus.m_last} !== 5'b0) begin
            bad++; $display("FAIL midrst_flags: got %b want 00000", {bus.busy, bus.done, bus.mem_rd_en, bus.m_valid, bus.m_last});
        end
        total++; if ({bus.mem_addr, bus.m_data, bus.m_type} !== 50'b0) begin
            bad++; $display("FAIL midrst_buses: got %h/%h/%0d want 0/0/0", bus.mem_addr, bus.m_data, bus.m_type);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (done_cnt != 0) begin bad++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt); end
        test_basic();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.m_ready = 1'b1;
        bus.mem_rd_data = '0;
        bus.scale_base = '0; bus.scale_len = '0;
        bus.weight_base = '0; bus.weight_len = '0;
        bus.bias_base = '0; bus.bias_len = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_weight();
        test_all_zero();
        test_wrap();
        test_start_while_busy();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
